// File: rtl/serial_comparator_ctrl.sv
// Bit-serial unsigned magnitude comparator, MSB first, with an IDLE/RUN/DONE controller.
// Optional early termination on the first differing bit: define SERIAL_CMP_EARLY_EXIT_EN.
module serial_comparator_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             eq,
  output logic             gt,
  output logic             lt
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             eq_acc_q, eq_acc_d;
  logic             gt_acc_q, gt_acc_d;
  logic             eq_q, eq_d;
  logic             gt_q, gt_d;
  logic             lt_q, lt_d;

  logic bit_a, bit_b, eq_step, gt_step, finish;

  // The current bit pair always sits in the MSB of the shift registers.
  assign bit_a   = a_sh_q[WIDTH-1];
  assign bit_b   = b_sh_q[WIDTH-1];
  assign eq_step = eq_acc_q & ~(bit_a ^ bit_b);
  assign gt_step = gt_acc_q | (eq_acc_q & bit_a & ~bit_b);

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    idx_d    = idx_q;
    eq_acc_d = eq_acc_q;
    gt_acc_d = gt_acc_q;
    eq_d     = eq_q;
    gt_d     = gt_q;
    lt_d     = lt_q;
    finish   = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_sh_d   = a;
          b_sh_d   = b;
          idx_d    = IW'(WIDTH - 1);
          eq_acc_d = 1'b1;
          gt_acc_d = 1'b0;
          state_d  = RUN;
        end
      end
      RUN: begin
        eq_acc_d = eq_step;
        gt_acc_d = gt_step;
        a_sh_d   = a_sh_q << 1;
        b_sh_d   = b_sh_q << 1;
        idx_d    = idx_q - IW'(1);
`ifdef SERIAL_CMP_EARLY_EXIT_EN
        finish   = (idx_q == '0) | ~eq_step;
`else
        finish   = (idx_q == '0);
`endif
        // Results are taken from the post-step accumulators so DONE shows them at once.
        if (finish) begin
          eq_d    = eq_step;
          gt_d    = gt_step;
          lt_d    = ~eq_step & ~gt_step;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      idx_q    <= '0;
      eq_acc_q <= 1'b0;
      gt_acc_q <= 1'b0;
      eq_q     <= 1'b0;
      gt_q     <= 1'b0;
      lt_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      idx_q    <= idx_d;
      eq_acc_q <= eq_acc_d;
      gt_acc_q <= gt_acc_d;
      eq_q     <= eq_d;
      gt_q     <= gt_d;
      lt_q     <= lt_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign eq   = eq_q;
  assign gt   = gt_q;
  assign lt   = lt_q;

endmodule

// File: tb/tb_serial_comparator_ctrl.sv
// Scoreboard bench for serial_comparator_ctrl: stimulus pushes expected results,
// a monitor pops and checks on every done pulse.
module tb_serial_comparator_ctrl;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             busy, done, eq, gt, lt;

  serial_comparator_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .eq    (eq),
    .gt    (gt),
    .lt    (lt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] res;   // {eq, gt, lt}
    int         len;   // expected busy cycles
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   held_mode = 0;
  int   cycle = 0;

  // Reference model: plain unsigned compare; run length from first differing bit.
  function automatic exp_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    exp_t e;
    e.res = (x == y) ? 3'b100 : (x > y) ? 3'b010 : 3'b001;
    e.len = WIDTH;
`ifdef SERIAL_CMP_EARLY_EXIT_EN
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (x[i] != y[i]) begin
        e.len = WIDTH - i;
        break;
      end
    end
`endif
    return e;
  endfunction

  task automatic check(input string name, input int act, input int req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Monitor: samples 1 time unit after each rising edge.
  initial begin : monitor
    int         busy_cnt = 0;
    logic       prev_done = 1'b0;
    logic       prev_busy = 1'b0;
    int         last_done = -100;
    logic [2:0] held_res = 3'b000;
    exp_t       e;
    forever begin
      @(posedge clk);
      #1;
      cycle++;
      if (rst) begin
        busy_cnt = 0;
        held_res = 3'b000;
        check("reset_outputs", {busy, done, eq, gt, lt}, 0);
      end else begin
        if (busy) busy_cnt++;
        if (busy && !prev_busy && held_mode != 0 && last_done >= 0)
          check("held_start_gap", cycle - last_done, 2);
        if (done) begin
          check("done_single_cycle", prev_done, 0);
          if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_done: got done=1 expected no pending result");
          end else begin
            e = exp_q.pop_front();
            check("result_eqgtlt", {eq, gt, lt}, e.res);
            check("busy_length", busy_cnt, e.len);
            $display("txn: eqgtlt=%b expected %b busy=%0d expected %0d", {eq, gt, lt}, e.res, busy_cnt, e.len);
          end
          held_res  = {eq, gt, lt};
          busy_cnt  = 0;
          last_done = cycle;
        end else begin
          check("result_hold", {eq, gt, lt}, held_res);
        end
      end
      prev_done = done;
      prev_busy = busy;
    end
  end

  // Wait for done (sampled at negedge), optionally disturbing inputs while running.
  task automatic wait_done(input bit perturb);
    bit seen = 0;
    for (int i = 0; i < 2 * WIDTH + 10; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1;
        break;
      end
      if (perturb) begin
        a     = WIDTH'($urandom);
        b     = WIDTH'($urandom);
        start = 1'($urandom);
      end
    end
    if (!seen) begin
      miscompares++;
      $display("FAIL done_timeout: got no done expected done within %0d cycles", 2 * WIDTH + 10);
    end
  endtask

  // One comparison: start at negedge while in IDLE, returns at the negedge in DONE.
  task automatic run_cmp(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input bit perturb);
    @(negedge clk);
    a = x;
    b = y;
    start = 1'b1;
    exp_q.push_back(model(x, y));
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", busy, 1);
    wait_done(perturb);
    start = 1'b0;
  endtask

  initial begin : stimulus
    logic [WIDTH-1:0] x, y;
    #1;
    check("reset_async_outputs", {busy, done, eq, gt, lt}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    run_cmp(8'hA5, 8'hA5, 0);
    run_cmp(8'h80, 8'h7F, 0);
    run_cmp(8'h00, 8'hFF, 0);
    run_cmp(8'hFE, 8'hFF, 0);
    run_cmp(8'h10, 8'h20, 1);
    run_cmp(8'h00, 8'h00, 0);
    run_cmp(8'hFF, 8'hFF, 0);
    run_cmp(8'h01, 8'h00, 0);

    // Reset in the 4th RUN cycle aborts without a done pulse.
    @(negedge clk);
    a = 8'h10;
    b = 8'h20;
    start = 1'b1;
    exp_q.push_back(model(8'h10, 8'h20));
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("busy_before_abort", busy, 1);
    rst = 1'b1;
    void'(exp_q.pop_back());
    #1;
    check("abort_async_clear", {busy, done, eq, gt, lt}, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_after_abort", {busy, done}, 0);
    run_cmp(8'h33, 8'h31, 0);

    // start held high for three back-to-back comparisons.
    @(negedge clk);
    held_mode = 1;
    a = 8'h12;
    b = 8'h34;
    start = 1'b1;
    exp_q.push_back(model(8'h12, 8'h34));
    for (int k = 0; k < 3; k++) begin
      wait_done(0);
      if (k < 2) begin
        x = WIDTH'($urandom);
        y = (k == 0) ? x : WIDTH'($urandom);
        a = x;
        b = y;
        exp_q.push_back(model(x, y));
      end
    end
    start = 1'b0;
    @(negedge clk);
    held_mode = 0;

    for (int n = 0; n < 40; n++) begin
      x = WIDTH'($urandom);
      case ($urandom_range(0, 3))
        0:       y = x;
        1:       y = x ^ WIDTH'(1 << $urandom_range(0, WIDTH - 1));
        default: y = WIDTH'($urandom);
      endcase
      run_cmp(x, y, n[0]);
    end

    repeat (3) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
